// File: rtl/gpu_fpu_issue.sv
// gpu_fpu_issue
//   Operand/issue stage in front of the combinational gpu_fpu. Instructions
//   (opcode, two operands, tag) are queued in a DEPTH-entry FIFO and issued
//   one at a time. After an issue the stage waits FPU_LAT cycles for fpu_out
//   to settle, captures it, and offers it to writeback on a valid/ready
//   channel. Results leave in issue order.
//
//   Optional feature, macro GPU_FPU_ILLEGAL_TRAP_EN:
//     defined   - an opcode outside 14..22 is not issued. fpu_* keep their old
//                 values and the FSM goes IDLE->DONE with res_data=0,
//                 res_err=1 and the tag preserved.
//     undefined - every opcode goes through EXEC; res_err is always 0.
//
// Ports
//   clk, rst                     clock (rising edge), async active-high reset
//   in_valid/in_ready            instruction handshake; in_ready = FIFO not full
//   in_opc, in_a, in_b, in_tag   instruction fields
//   fpu_opc, fpu_in1, fpu_in2    registered operands to gpu_fpu, loaded on issue
//   fpu_out                      combinational result from gpu_fpu
//   res_valid/res_ready          writeback handshake
//   res_data, res_tag, res_err   captured result, its tag, illegal-opcode flag
//   count                        FIFO occupancy (0..DEPTH)
//   busy                         FSM not idle or FIFO not empty
module gpu_fpu_issue #(
  parameter int DATA_W  = 33,
  parameter int OPC_W   = 6,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int FPU_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPC_W-1:0]         in_opc,
  input  logic [DATA_W-1:0]        in_a,
  input  logic [DATA_W-1:0]        in_b,
  input  logic [TAG_W-1:0]         in_tag,
  output logic [OPC_W-1:0]         fpu_opc,
  output logic [DATA_W-1:0]        fpu_in1,
  output logic [DATA_W-1:0]        fpu_in2,
  input  logic [DATA_W-1:0]        fpu_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [DATA_W-1:0]        res_data,
  output logic [TAG_W-1:0]         res_tag,
  output logic                     res_err,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LAT_W = (FPU_LAT > 1) ? $clog2(FPU_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [LAT_W-1:0]   r_lat_cnt;
  logic [TAG_W-1:0]   r_tag;

  logic [OPC_W-1:0]   r_mem_opc [DEPTH];
  logic [DATA_W-1:0]  r_mem_a   [DEPTH];
  logic [DATA_W-1:0]  r_mem_b   [DEPTH];
  logic [TAG_W-1:0]   r_mem_tag [DEPTH];

  logic w_push, w_pop, w_trap, w_capture, w_head_illegal;

  // ---- FIFO input stage ----
  assign in_ready = (r_count != CNT_W'(DEPTH));
  assign w_push   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_opc[r_wr_ptr] <= in_opc;
      r_mem_a[r_wr_ptr]   <= in_a;
      r_mem_b[r_wr_ptr]   <= in_b;
      r_mem_tag[r_wr_ptr] <= in_tag;
    end
  end

`ifdef GPU_FPU_ILLEGAL_TRAP_EN
  assign w_head_illegal = (r_mem_opc[r_rd_ptr] < OPC_W'(14)) ||
                          (r_mem_opc[r_rd_ptr] > OPC_W'(22));
`else
  assign w_head_illegal = 1'b0;
`endif

  // ---- issue FSM ----
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_trap      = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop = 1'b1;
          if (w_head_illegal) begin
            w_trap      = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        // lat_cnt is 0 in the first EXEC cycle, so the FPU_LAT-th cycle is FPU_LAT-1
        if (r_lat_cnt == LAT_W'(FPU_LAT - 1)) begin
          w_capture   = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_lat_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_pop)                  r_lat_cnt <= '0;
      else if (r_state == S_EXEC) r_lat_cnt <= r_lat_cnt + LAT_W'(1);
    end
  end

  // ---- FPU operand / result registers ----
  // Operands change only on a real issue so gpu_fpu sees stable inputs in EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpu_opc  <= '0;
      fpu_in1  <= '0;
      fpu_in2  <= '0;
      r_tag    <= '0;
      res_data <= '0;
      res_tag  <= '0;
      res_err  <= 1'b0;
    end else begin
      if (w_pop && !w_trap) begin
        fpu_opc <= r_mem_opc[r_rd_ptr];
        fpu_in1 <= r_mem_a[r_rd_ptr];
        fpu_in2 <= r_mem_b[r_rd_ptr];
        r_tag   <= r_mem_tag[r_rd_ptr];
      end
      if (w_trap) begin
        res_data <= '0;
        res_tag  <= r_mem_tag[r_rd_ptr];
        res_err  <= 1'b1;
      end else if (w_capture) begin
        res_data <= fpu_out;
        res_tag  <= r_tag;
        res_err  <= 1'b0;
      end
    end
  end

  assign res_valid = (r_state == S_DONE);
  assign count     = r_count;
  assign busy      = (r_state != S_IDLE) || (r_count != '0);

endmodule

// File: tb/tb_gpu_fpu_issue.sv
module tb_gpu_fpu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opc;
  logic [32:0] in_a, in_b;
  logic [3:0]  in_tag;
  logic [5:0]  fpu_opc;
  logic [32:0] fpu_in1, fpu_in2, fpu_out;
  logic        res_valid, res_ready;
  logic [32:0] res_data;
  logic [3:0]  res_tag;
  logic        res_err;
  logic [2:0]  count;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gpu_fpu_issue dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_opc(in_opc),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .fpu_opc(fpu_opc), .fpu_in1(fpu_in1), .fpu_in2(fpu_in2), .fpu_out(fpu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .res_err(res_err), .count(count), .busy(busy)
  );

  // Stand-in gpu_fpu: add for opcode 14, subtract for 15, zero otherwise.
  always_comb begin
    fpu_out = '0;
    if (fpu_opc == 6'd14)      fpu_out = fpu_in1 + fpu_in2;
    else if (fpu_opc == 6'd15) fpu_out = fpu_in1 - fpu_in2;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [5:0] o, input logic [32:0] a, input logic [32:0] b,
                       input logic [3:0] t);
    int n;
    in_opc = o; in_a = a; in_b = b; in_tag = t; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (!in_ready) chk("push_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input string tag, input logic [32:0] d, input logic [3:0] t,
                          input logic e);
    int n;
    n = 0;
    while (!res_valid && n < 30) begin tick(); n++; end
    if (!res_valid) chk({tag, "_timeout"}, 0, 1);
    else begin
      chk({tag, "_data"}, res_data, d);
      chk({tag, "_tag"}, res_tag, t);
      chk({tag, "_err"}, res_err, e);
    end
    tick();
  endtask

  logic [32:0] exp_d [20];
  logic [3:0]  exp_t [20];

  initial begin
    int acc, got, seen;
    rst = 1'b1; in_valid = 1'b0; in_opc = '0; in_a = '0; in_b = '0; in_tag = '0;
    res_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);

    // single add, result 8 tag 2
    push1(6'd14, 33'd5, 33'd3, 4'd2);
    tick();
    chk("t2_fpu_opc", fpu_opc, 14);
    chk("t2_fpu_in1", fpu_in1, 5);
    chk("t2_early_valid", res_valid, 0);
    tick();
    chk("t2_valid", res_valid, 1);
    chk("t2_data", res_data, 8);
    chk("t2_tag", res_tag, 2);
    tick();
    chk("t2_busy", busy, 0);
    chk("t2_valid_drop", res_valid, 0);

    // mid-cycle async reset clears everything immediately
    #3 rst = 1'b1;
    #1;
    chk("t1_fpu_opc", fpu_opc, 0);
    chk("t1_fpu_in1", fpu_in1, 0);
    chk("t1_res_data", res_data, 0);
    chk("t1_res_tag", res_tag, 0);
    chk("t1_count", count, 0);
    chk("t1_in_ready", in_ready, 1);
    chk("t1_busy", busy, 0);
    #1 rst = 1'b0;
    tick();

    // backpressure: 6 offered, 5 accepted (4 FIFO + 1 in DONE)
    res_ready = 1'b0;
    acc = 0;
    in_opc = 6'd15; in_a = 33'd10; in_b = 33'd4;
    for (int c = 0; c < 12; c++) begin
      in_tag = 4'(acc); in_valid = 1'b1;
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    chk("t3_accepted", acc, 5);
    chk("t3_count_full", count, 4);
    chk("t3_in_ready_full", in_ready, 0);
    for (int c = 0; c < 10; c++) begin
      chk("t3_hold", {res_valid, res_tag, res_data}, {1'b1, 4'd0, 33'd6});
      tick();
    end
    res_ready = 1'b1;
    wait_res("t3_r0", 33'd6, 4'd0, 1'b0);
    chk("t3_no_push_on_pop", in_ready, 0);
    tick();
    chk("t3_count_after_pop", count, 3);
    chk("t3_in_ready_after_pop", in_ready, 1);
    for (int i = 1; i < 5; i++) wait_res("t3_rn", 33'd6, 4'(i), 1'b0);
    chk("t3_drained", busy, 0);

    // 20 back-to-back ops, random writeback stalls
    for (int i = 0; i < 20; i++) begin
      exp_t[i] = 4'(i % 16);
      if (i % 2 == 0) exp_d[i] = 33'(i * 3 + 1) + 33'(i * 5);
      else            exp_d[i] = 33'(i * 3 + 1) - 33'(i * 5);
    end
    got = 0;
    fork
      begin
        int i, g;
        i = 0; g = 0;
        while (i < 20 && g < 600) begin
          in_opc = (i % 2 == 0) ? 6'd14 : 6'd15;
          in_a = 33'(i * 3 + 1); in_b = 33'(i * 5); in_tag = 4'(i % 16);
          in_valid = 1'b1;
          if (in_ready) i++;
          tick(); g++;
        end
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 800 && got < 20; c++) begin
          res_ready = 1'($urandom_range(0, 1));
          if (res_valid && res_ready) begin
            chk("t4_data", res_data, exp_d[got]);
            chk("t4_tag", res_tag, exp_t[got]);
            got++;
          end
          tick();
        end
        res_ready = 1'b1;
      end
    join
    chk("t4_count", got, 20);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (res_valid) seen = 1;
      tick();
    end
    chk("t4_no_dup", seen, 0);

    // reset during EXEC with two ops queued
    res_ready = 1'b1;
    in_valid = 1'b1; in_opc = 6'd14; in_a = 33'd1; in_b = 33'd1; in_tag = 4'd1;
    tick();
    in_a = 33'd20; in_b = 33'd2; in_tag = 4'd2;
    tick();
    in_tag = 4'd3;
    tick();
    chk("t5_first_data", {res_valid, res_data}, {1'b1, 33'd2});
    in_tag = 4'd4;
    tick();
    in_valid = 1'b0;
    tick();
    chk("t5_exec_count", count, 2);
    chk("t5_exec_valid", res_valid, 0);
    chk("t5_exec_opc", fpu_opc, 14);
    #3 rst = 1'b1;
    #1;
    chk("t5_rst_count", count, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_opc", fpu_opc, 0);
    #1 rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (res_valid) seen = 1;
    end
    chk("t5_quiet", seen, 0);
    push1(6'd15, 33'd9, 33'd2, 4'd5);
    wait_res("t5_after", 33'd7, 4'd5, 1'b0);

    // illegal opcode 30
    push1(6'd30, 33'd11, 33'd12, 4'd7);
    tick();
`ifdef GPU_FPU_ILLEGAL_TRAP_EN
    chk("t6_valid", res_valid, 1);
    chk("t6_err", res_err, 1);
    chk("t6_data", res_data, 0);
    chk("t6_tag", res_tag, 7);
    chk("t6_opc_kept", fpu_opc, 15);
    tick();
`else
    chk("t6_opc", fpu_opc, 30);
    chk("t6_in2", fpu_in2, 12);
    chk("t6_early_valid", res_valid, 0);
    tick();
    chk("t6_valid", res_valid, 1);
    chk("t6_err", res_err, 0);
    chk("t6_tag", res_tag, 7);
    chk("t6_data", res_data, 0);
    tick();
`endif
    chk("t6_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
